// File: rtl/lsq_mem_port.sv
// Memory-side responder for the load/store queue: takes one popped request,
// runs it over the req/ack data-memory bus and returns a tagged response.
module lsq_mem_port #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TAG_WIDTH      = 7,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      async_rst_n,
    input  logic                      clk_en,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_load_store,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic [TAG_WIDTH-1:0]      req_tag,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      mem_err,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [TAG_WIDTH-1:0]      rsp_tag,
    output logic                      rsp_is_store,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     timeout_cnt;
    logic [TAG_WIDTH-1:0] lat_tag;
    logic                 lat_store;
    logic                 misaligned;
    logic                 timeout_hit;

    assign misaligned  = (req_addr % MEM_ADDR_WIDTH'(BYTES)) != '0;
    // The counter holds the number of ack-less edges so far, so the edge that
    // would bring it to TIMEOUT_CYCLES is the one that aborts.
    assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign req_ready   = (state == IDLE) && clk_en;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state        <= IDLE;
            timeout_cnt  <= '0;
            lat_tag      <= '0;
            lat_store    <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_tag      <= '0;
            rsp_is_store <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_tag   <= req_tag;
                        lat_store <= req_load_store;
                        if (misaligned) begin
                            state        <= RESP;
                            rsp_valid    <= 1'b1;
                            rsp_tag      <= req_tag;
                            rsp_is_store <= req_load_store;
                            rsp_data     <= '0;
                            rsp_err      <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            timeout_cnt <= '0;
                            mem_req     <= 1'b1;
                            mem_we      <= req_load_store;
                            mem_addr    <= req_addr;
                            mem_wdata   <= req_data;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ack || timeout_hit) begin
                        state        <= RESP;
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        mem_addr     <= '0;
                        mem_wdata    <= '0;
                        rsp_valid    <= 1'b1;
                        rsp_tag      <= lat_tag;
                        rsp_is_store <= lat_store;
                        // An ack arriving on the expiring edge still counts as a normal completion.
                        if (mem_ack) begin
                            rsp_data <= (lat_store || mem_err) ? '0 : mem_rdata;
                            rsp_err  <= mem_err;
                        end else begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state        <= IDLE;
                        rsp_valid    <= 1'b0;
                        rsp_tag      <= '0;
                        rsp_is_store <= 1'b0;
                        rsp_data     <= '0;
                        rsp_err      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsq_mem_port.sv
// Scoreboard bench for lsq_mem_port: a driver issues requests with a planned
// memory behaviour, a memory model and a response monitor check independently.
module tb_lsq_mem_port;

    localparam int T = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic        err;
    } plan_t;

    typedef struct {
        logic [6:0]  tag;
        logic        is_store;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        async_rst_n;
    logic        clk_en;
    logic        req_valid;
    logic        req_ready;
    logic        req_load_store;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [6:0]  req_tag;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [6:0]  rsp_tag;
    logic        rsp_is_store;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    plan_t plan_q[$];
    rsp_t  exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    en_mode = 1;
    int    ready_mode = 1;
    bit    flush = 1'b0;
    bit    directed = 1'b1;
    logic  edge_en = 1'b0;

    lsq_mem_port #(
        .MEM_ADDR_WIDTH(32),
        .DATA_WIDTH    (32),
        .TAG_WIDTH     (7),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk           (clk),
        .async_rst_n   (async_rst_n),
        .clk_en        (clk_en),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_load_store(req_load_store),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tag       (rsp_tag),
        .rsp_is_store  (rsp_is_store),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_en <= clk_en;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference behaviour: misaligned or unacknowledged-for-T-edges requests are errors.
    function automatic rsp_t model_rsp(input logic ls, input logic [31:0] addr, input logic [6:0] tag,
                                       input int delay, input logic [31:0] rdata, input logic err);
        rsp_t r;
        r.tag      = tag;
        r.is_store = ls;
        if ((addr % 4) != 0 || delay >= T) begin
            r.err  = 1'b1;
            r.data = 32'h0;
        end else begin
            r.err  = err;
            r.data = (ls || err) ? 32'h0 : rdata;
        end
        return r;
    endfunction

    function automatic int exp_edges(input int delay);
        return (delay < T) ? delay + 1 : T;
    endfunction

    initial begin
        clk_en    = 1'b1;
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (en_mode)
                0:       clk_en = ($urandom_range(0, 99) < 85);
                1:       clk_en = 1'b1;
                default: clk_en = 1'b0;
            endcase
            rsp_ready = (ready_mode == 0) ? ($urandom_range(0, 99) < 70) : (ready_mode == 1);
        end
    end

    // Memory model: acks after the planned number of enabled ISSUE edges and holds ack while mem_req stays high.
    initial begin
        plan_t cur;
        int    waited = 0;
        int    edges = 0;
        bit    active = 1'b0;
        cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, delay: 0, rdata: 32'h0, err: 1'b0};
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        mem_err   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (flush) begin
                active  = 1'b0;
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    if (plan_q.size() == 0) begin
                        check_output("spurious_mem_req", 64'(mem_req), 64'(0));
                    end else begin
                        cur = plan_q.pop_front();
                    end
                    active = 1'b1;
                    waited = 0;
                    edges  = 0;
                end else if (edge_en) begin
                    edges++;
                    if (!mem_ack) waited++;
                end
                check_output("mem_we", 64'(mem_we), 64'(cur.we));
                check_output("mem_addr", 64'(mem_addr), 64'(cur.addr));
                check_output("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
                if (!mem_ack && waited == cur.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = cur.rdata;
                    mem_err   = cur.err;
                end
            end else begin
                if (active) begin
                    edges++;
                    check_output("issue_edges", 64'(edges), 64'(exp_edges(cur.delay)));
                    active = 1'b0;
                end
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                mem_err   = 1'($urandom_range(0, 1));
                check_output("mem_idle_zero", 64'({mem_we, mem_addr, mem_wdata}), 64'(0));
            end
        end
    end

    // Response monitor: every cycle a response is presented it must match the scoreboard head.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid || mem_req) check_output("busy", 64'(busy), 64'(1));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_output("spurious_rsp", 64'(rsp_valid), 64'(0));
                end else begin
                    e = exp_q[0];
                    check_output("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                    check_output("rsp_is_store", 64'(rsp_is_store), 64'(e.is_store));
                    check_output("rsp_data", 64'(rsp_data), 64'(e.data));
                    check_output("rsp_err", 64'(rsp_err), 64'(e.err));
                    check_output("req_ready_in_resp", 64'(req_ready), 64'(0));
                    if (rsp_ready && clk_en) void'(exp_q.pop_front());
                end
            end else begin
                check_output("rsp_idle_zero", 64'({rsp_tag, rsp_is_store, rsp_data, rsp_err}), 64'(0));
            end
        end
    end

    task automatic apply_stimulus(input logic ls, input logic [31:0] addr, input logic [31:0] data,
                                  input logic [6:0] tag, input int delay, input logic [31:0] rdata,
                                  input logic err, input bit stall);
        bit accepted = 1'b0;
        bit aligned  = (addr % 4) == 0;
        @(posedge clk);
        #2;
        req_valid      = 1'b1;
        req_load_store = ls;
        req_addr       = addr;
        req_data       = data;
        req_tag        = tag;
        for (int i = 0; i < 500 && !accepted; i++) begin
            @(negedge clk);
            if (req_ready) accepted = 1'b1;
        end
        if (!accepted) begin
            check_output("accept_timeout", 64'(accepted), 64'(1));
        end else begin
            exp_q.push_back(model_rsp(ls, addr, tag, delay, rdata, err));
            if (aligned) plan_q.push_back('{we: ls, addr: addr, wdata: data, delay: delay, rdata: rdata, err: err});
            if (stall) en_mode = 2;
        end
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_tag   = 7'($urandom);
        if (accepted && directed && !stall) begin
            @(negedge clk);
            if (!aligned) begin
                check_output("misaligned_latency_valid", 64'(rsp_valid), 64'(1));
                check_output("misaligned_no_mem_req", 64'(mem_req), 64'(0));
            end else begin
                check_output("issue_latency_mem_req", 64'(mem_req), 64'(1));
                if (delay == 0) begin
                    @(negedge clk);
                    check_output("zero_wait_rsp_latency", 64'(rsp_valid), 64'(1));
                end
            end
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && plan_q.size() == 0 && !busy) done = 1'b1;
        end
        check_output("drain_done", 64'(done), 64'(1));
    endtask

    initial begin
        bit seen;
        logic [31:0] a;
        async_rst_n    = 1'b0;
        req_valid      = 1'b0;
        req_load_store = 1'b0;
        req_addr       = 32'h0;
        req_data       = 32'h0;
        req_tag        = 7'h0;
        #12;
        check_output("reset_mem_req", 64'(mem_req), 64'(0));
        check_output("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check_output("reset_busy", 64'(busy), 64'(0));
        check_output("reset_rsp_data", 64'(rsp_data), 64'(0));
        #1 async_rst_n = 1'b1;

        apply_stimulus(1'b0, 32'h0000_0010, 32'h0, 7'd5, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        wait_idle();
        apply_stimulus(1'b1, 32'h0000_0020, 32'h1234_5678, 7'd9, 3, 32'hAAAA_5555, 1'b0, 1'b0);
        wait_idle();
        apply_stimulus(1'b0, 32'h0000_0003, 32'h0, 7'd3, 0, 32'h1111_2222, 1'b0, 1'b0);
        wait_idle();

        ready_mode = 2;
        apply_stimulus(1'b0, 32'h0000_0040, 32'h0, 7'd17, 50, 32'h3333_4444, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        check_output("timeout_rsp_seen", 64'(seen), 64'(1));
        repeat (3) @(negedge clk);
        ready_mode = 1;
        wait_idle();

        apply_stimulus(1'b0, 32'h0000_0080, 32'h0, 7'd33, 0, 32'hCAFE_F00D, 1'b0, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #3;
            check_output("stall_mem_req", 64'(mem_req), 64'(1));
            check_output("stall_mem_ack", 64'(mem_ack), 64'(1));
        end
        en_mode = 1;
        wait_idle();

        directed = 1'b0;
        en_mode = 0;
        ready_mode = 0;
        for (int n = 0; n < 150; n++) begin
            a = $urandom;
            a[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            apply_stimulus(1'($urandom_range(0, 1)), a, $urandom, 7'($urandom), $urandom_range(0, 6),
                           $urandom, ($urandom_range(0, 5) == 0), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle();

        en_mode = 1;
        ready_mode = 1;
        directed = 1'b1;
        apply_stimulus(1'b0, 32'h0000_0100, 32'h0, 7'd44, 50, 32'h5555_6666, 1'b0, 1'b0);
        #1;
        flush = 1'b1;
        async_rst_n = 1'b0;
        #1;
        check_output("async_reset_mem_req", 64'(mem_req), 64'(0));
        check_output("async_reset_busy", 64'(busy), 64'(0));
        check_output("async_reset_rsp_valid", 64'(rsp_valid), 64'(0));
        exp_q.delete();
        plan_q.delete();
        @(posedge clk);
        #3 async_rst_n = 1'b1;
        @(posedge clk);
        #3 flush = 1'b0;
        apply_stimulus(1'b0, 32'h0000_0104, 32'h0, 7'd45, 1, 32'h0BAD_F00D, 1'b0, 1'b0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
